parser_conf_ctrl: RTL and testbench

PARSER_CONF_CTRL -- requirements
Module: parser_conf_ctrl

---
 rtl/parser_conf_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_parser_conf_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parser_conf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : parser_conf_ctrl
// Purpose  : Arbitrates rule-table configuration accesses from two requesters
//            (0 = host, 1 = local CPU) onto LAYER_NUM Parser_Layer rule ports.
//            One transaction is in flight at a time: grant -> one-cycle
//            write/read strobe -> optional wait for read data (with timeout)
//            -> response held until accepted.
// Ports    :
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   per-requester request handshake (ready = grant)
//   i_req_wr/addr/wdata       per-requester command; addr[31:24] = layer
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_id/err/rdata       response owner, error flag, read data
//   o_rule_wren/rden          one-hot, one-cycle strobes per layer
//   o_rule_addr/wdata         shared rule address / write data
//   i_rule_rdata_valid/rdata  per-layer read return
// Revision : 1.0 - initial release
// ============================================================================
module parser_conf_ctrl #(
  parameter int LAYER_NUM  = 4,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [1:0]                 i_req_valid,
  output logic [1:0]                 o_req_ready,
  input  logic [1:0]                 i_req_wr,
  input  logic [1:0][31:0]           i_req_addr,
  input  logic [1:0][31:0]           i_req_wdata,
  output logic                       o_resp_valid,
  input  logic                       i_resp_ready,
  output logic                       o_resp_id,
  output logic                       o_resp_err,
  output logic [31:0]                o_resp_rdata,
  output logic [LAYER_NUM-1:0]       o_rule_wren,
  output logic [LAYER_NUM-1:0]       o_rule_rden,
  output logic [31:0]                o_rule_addr,
  output logic [31:0]                o_rule_wdata,
  input  logic [LAYER_NUM-1:0]       i_rule_rdata_valid,
  input  logic [LAYER_NUM-1:0][31:0] i_rule_rdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT_RD = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [7:0]  C_TIMEOUT      = 8'(RD_TIMEOUT);
  localparam logic [31:0] C_LAYER_NUM    = 32'(LAYER_NUM);
  localparam logic [31:0] C_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // State
  logic [1:0]           r_state;
  logic                 r_last_gnt;
  logic [7:0]           r_cnt;
  logic                 r_wr;
  logic [7:0]           r_layer;
  logic [31:0]          r_rule_addr;
  logic [31:0]          r_rule_wdata;
  logic [LAYER_NUM-1:0] r_wren;
  logic [LAYER_NUM-1:0] r_rden;
  logic                 r_resp_valid;
  logic                 r_resp_id;
  logic                 r_resp_err;
  logic [31:0]          r_resp_rdata;

  // Arbitration / decode
  logic                 w_any_valid;
  logic                 w_gnt_id;
  logic                 w_grant;
  logic [31:0]          w_gnt_addr;
  logic [7:0]           w_gnt_layer;
  logic                 w_gnt_bad;
  logic [LAYER_NUM-1:0] w_gnt_oh;
  logic [LAYER_NUM-1:0] w_cur_oh;
  logic                 w_sel_valid;
  logic [31:0]          w_sel_data;
  logic [7:0]           w_cnt_nxt;

  assign w_any_valid = |i_req_valid;
  // On a tie the requester not granted last wins; otherwise the lone requester.
  assign w_gnt_id    = (&i_req_valid) ? ~r_last_gnt : i_req_valid[1];
  assign w_grant     = (r_state == S_IDLE) && w_any_valid;
  assign w_gnt_addr  = i_req_addr[w_gnt_id];
  assign w_gnt_layer = w_gnt_addr[31:24];
  assign w_gnt_bad   = ({24'd0, w_gnt_layer} >= C_LAYER_NUM);

  // Ready is the grant itself, so it must be combinational with the valid it
  // answers; it is also forced low while reset is held.
  assign o_req_ready = (w_grant && i_rst_n) ? (w_gnt_id ? 2'b10 : 2'b01) : 2'b00;

  generate
    for (genvar gi = 0; gi < LAYER_NUM; gi++) begin : g_layer_dec
      assign w_gnt_oh[gi] = (w_gnt_layer == 8'(gi));
      assign w_cur_oh[gi] = (r_layer == 8'(gi));
    end
  endgenerate

  // Only the addressed layer's return is observed; other layers are masked.
  assign w_sel_valid = |(i_rule_rdata_valid & w_cur_oh);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < LAYER_NUM; i++) begin
      if (w_cur_oh[i]) w_sel_data = w_sel_data | i_rule_rdata[i];
    end
  end

  assign w_cnt_nxt = r_cnt + 8'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_last_gnt   <= 1'b1;
      r_cnt        <= '0;
      r_wr         <= 1'b0;
      r_layer      <= '0;
      r_rule_addr  <= '0;
      r_rule_wdata <= '0;
      r_wren       <= '0;
      r_rden       <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      // Strobes are single-cycle: they are only set on the grant edge.
      r_wren <= '0;
      r_rden <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_last_gnt   <= w_gnt_id;
            r_wr         <= i_req_wr[w_gnt_id];
            r_layer      <= w_gnt_layer;
            r_rule_addr  <= {8'd0, w_gnt_addr[23:0]};
            r_rule_wdata <= i_req_wdata[w_gnt_id];
            r_resp_id    <= w_gnt_id;
            if (w_gnt_bad) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state <= S_ISSUE;
              if (i_req_wr[w_gnt_id]) r_wren <= w_gnt_oh;
              else                    r_rden <= w_gnt_oh;
            end
          end
        end
        S_ISSUE: begin
          if (r_wr) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
          end else if (w_sel_valid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_sel_data;
          end else begin
            r_state <= S_WAIT_RD;
            r_cnt   <= '0;
          end
        end
        S_WAIT_RD: begin
          // Data arriving in the final waiting cycle still beats the timeout.
          if (w_sel_valid) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_sel_data;
          end else if (w_cnt_nxt == C_TIMEOUT) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= C_TIMEOUT_DATA;
            r_cnt        <= w_cnt_nxt;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rule_wren  = r_wren;
  assign o_rule_rden  = r_rden;
  assign o_rule_addr  = r_rule_addr;
  assign o_rule_wdata = r_rule_wdata;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_id    = r_resp_id;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_parser_conf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_parser_conf_ctrl
// Purpose  : Self-checking bench for parser_conf_ctrl. Requests push their
//            expected strobe and response into queues when granted; two
//            monitors pop and compare whenever the DUT shows a strobe or a
//            accepted response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_parser_conf_ctrl;

  localparam int LN = 4;
  localparam int RT = 15;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct packed {
    logic [3:0]  wren;
    logic [3:0]  rden;
    logic [31:0] addr;
    logic [31:0] wdata;
  } strb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          rq_valid;
  logic [1:0]          rq_ready;
  logic [1:0]          rq_wr;
  logic [1:0][31:0]    rq_addr;
  logic [1:0][31:0]    rq_wdata;
  logic                resp_valid;
  logic                resp_ready;
  logic                resp_id;
  logic                resp_err;
  logic [31:0]         resp_rdata;
  logic [LN-1:0]       rule_wren;
  logic [LN-1:0]       rule_rden;
  logic [31:0]         rule_addr;
  logic [31:0]         rule_wdata;
  logic [LN-1:0]       rl_valid;
  logic [LN-1:0][31:0] rl_data;

  parser_conf_ctrl #(.LAYER_NUM(LN), .RD_TIMEOUT(RT)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_req_valid        (rq_valid),
    .o_req_ready        (rq_ready),
    .i_req_wr           (rq_wr),
    .i_req_addr         (rq_addr),
    .i_req_wdata        (rq_wdata),
    .o_resp_valid       (resp_valid),
    .i_resp_ready       (resp_ready),
    .o_resp_id          (resp_id),
    .o_resp_err         (resp_err),
    .o_resp_rdata       (resp_rdata),
    .o_rule_wren        (rule_wren),
    .o_rule_rden        (rule_rden),
    .o_rule_addr        (rule_addr),
    .o_rule_wdata       (rule_wdata),
    .i_rule_rdata_valid (rl_valid),
    .i_rule_rdata       (rl_data)
  );

  int    n_chk  = 0;
  int    n_pass = 0;
  resp_t exp_q[$];
  strb_t strb_q[$];
  int    gnt_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
  endtask

  // Raise a request, wait (bounded) for its grant, record expectations.
  task automatic send(input int r, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err);
    bit    got;
    resp_t e;
    strb_t s;
    logic [3:0] oh;
    got = 0;
    rq_valid[r] = 1'b1;
    rq_wr[r]    = wr;
    rq_addr[r]  = addr;
    rq_wdata[r] = wdata;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rq_ready[r]) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL grant_timeout req%0d: got no grant, expected one within 200 cycles", r);
      rq_valid[r] = 1'b0;
      return;
    end
    gnt_log.push_back(r);
    e.id = r[0]; e.err = exp_err; e.rdata = exp_rdata;
    exp_q.push_back(e);
    if (addr[31:24] < 8'(LN)) begin
      oh = 4'b0001 << addr[25:24];
      s.wren  = wr ? oh : 4'b0000;
      s.rden  = wr ? 4'b0000 : oh;
      s.addr  = {8'h00, addr[23:0]};
      s.wdata = wdata;
      strb_q.push_back(s);
    end
    @(posedge clk); #1;
    rq_valid[r] = 1'b0;
  endtask

  // Count negedges until o_resp_valid, starting at the next negedge (k=0).
  task automatic wait_resp(input int exp_k, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!resp_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(nm, k, exp_k);
  endtask

  // Response monitor: compare on every accepted response.
  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL resp_unexpected: got id=%0d err=%0d rdata=%h, expected none", resp_id, resp_err, resp_rdata);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        chk("resp_id", resp_id, e.id);
        chk("resp_err", resp_err, e.err);
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end
  end

  // Strobe monitor: every cycle with a strobe must match one expectation.
  always @(negedge clk) begin
    if (rst_n && ((rule_wren | rule_rden) != '0)) begin
      if (strb_q.size() == 0) begin
        n_chk++;
        $display("FAIL strobe_unexpected: got wren=%b rden=%b, expected none", rule_wren, rule_rden);
      end else begin
        strb_t s;
        s = strb_q.pop_front();
        chk("rule_wren", rule_wren, s.wren);
        chk("rule_rden", rule_rden, s.rden);
        chk("rule_addr", rule_addr, s.addr);
        chk("rule_wdata", rule_wdata, s.wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int quiet;
    rq_valid = '0; rq_wr = '0; rq_addr = '0; rq_wdata = '0;
    rl_valid = '0; rl_data = '0;
    resp_ready = 1'b1;

    // Reset state, including ready gating while requests are presented.
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rq_valid = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", rq_ready, 0);
    chk("rst_wren", rule_wren, 0);
    chk("rst_rden", rule_rden, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rule_addr", rule_addr, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rq_valid = 2'b00;
    @(posedge clk); #1 rst_n = 1'b1;

    // Two concurrent streams of three writes: grants must alternate 0,1,0,...
    gnt_log.delete();
    fork
      begin
        for (int k = 0; k < 3; k++)
          send(0, 1'b1, {8'(k), 24'h000100 + 24'(k)}, 32'hA000_0000 + 32'(k), 32'h0, 1'b0);
      end
      begin
        for (int k = 0; k < 3; k++)
          send(1, 1'b1, {8'(3 - k), 24'h000200 + 24'(k)}, 32'hB000_0000 + 32'(k), 32'h0, 1'b0);
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("rr_count", gnt_log.size(), 6);
    for (int i = 0; i < gnt_log.size() && i < 6; i++) chk("rr_order", gnt_log[i], i % 2);

    // Directed write to layer 2.
    send(0, 1'b1, 32'h0200_0005, 32'hA5A5_0001, 32'h0, 1'b0);
    wait_resp(1, "wr_latency");
    @(posedge clk); #1;

    // Read layer 1, data valid three cycles after the read strobe.
    rl_data[1] = 32'hFFFF_0000;
    send(0, 1'b0, 32'h0100_0040, 32'h0, 32'h1234_5678, 1'b0);
    repeat (3) @(posedge clk);
    #1 rl_valid[1] = 1'b1; rl_data[1] = 32'h1234_5678;
    @(posedge clk);
    #1 rl_valid[1] = 1'b0; rl_data[1] = 32'h0;
    wait_resp(0, "rd_delay3_latency");
    @(posedge clk); #1;

    // Read layer 3 that never returns; a foreign layer's valid must be ignored.
    rl_valid[0] = 1'b1; rl_data[0] = 32'h0BAD_0BAD;
    send(1, 1'b0, 32'h0300_0000, 32'h0, 32'hDEAD_BEEF, 1'b1);
    wait_resp(RT + 1, "rd_timeout_latency");
    @(posedge clk); #1;
    rl_valid[0] = 1'b0; rl_data[0] = 32'h0;

    // Read layer 3 with data on the last waiting cycle: data wins.
    send(1, 1'b0, 32'h0300_0004, 32'h0, 32'hC0FF_EE00, 1'b0);
    repeat (RT) @(posedge clk);
    #1 rl_valid[3] = 1'b1; rl_data[3] = 32'hC0FF_EE00;
    @(posedge clk);
    #1 rl_valid[3] = 1'b0; rl_data[3] = 32'h0;
    wait_resp(0, "rd_last_cycle_latency");
    @(posedge clk); #1;

    // Read layer 2 with data already valid in the strobe cycle.
    rl_valid[2] = 1'b1; rl_data[2] = 32'h5A5A_A5A5;
    send(0, 1'b0, 32'h0200_0008, 32'h0, 32'h5A5A_A5A5, 1'b0);
    wait_resp(1, "rd_immediate_latency");
    @(posedge clk); #1;
    rl_valid[2] = 1'b0; rl_data[2] = 32'h0;

    // Layer 9 does not exist: error response one cycle after grant, no strobe.
    send(1, 1'b1, 32'h0900_0000, 32'h7777_7777, 32'h0, 1'b1);
    wait_resp(0, "bad_layer_latency");
    @(posedge clk); #1;

    // Response back-pressure with a competing request pending.
    resp_ready = 1'b0;
    fork
      send(0, 1'b1, 32'h0000_0010, 32'h1111_2222, 32'h0, 1'b0);
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!resp_valid && k < 40) begin
          @(negedge clk);
          k++;
        end
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_valid", resp_valid, 1);
          chk("stall_id", resp_id, 0);
          chk("stall_err", resp_err, 0);
          chk("stall_rdata", resp_rdata, 0);
          chk("stall_req_ready", rq_ready, 0);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        send(1, 1'b1, 32'h0100_0020, 32'h3333_4444, 32'h0, 1'b0);
      end
    join
    repeat (4) @(posedge clk); #1;

    // Reset while a read waits for data: everything clears, nothing follows.
    send(0, 1'b0, 32'h0200_0000, 32'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rden", rule_rden, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_resp_err", resp_err, 0);
    chk("arst_rule_addr", rule_addr, 0);
    chk("arst_rule_wdata", rule_wdata, 0);
    exp_q.delete();
    strb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid || (rule_wren != '0) || (rule_rden != '0)) quiet++;
    end
    chk("post_reset_quiet", quiet, 0);

    // First tie after reset goes to requester 0 again.
    @(posedge clk); #1;
    gnt_log.delete();
    fork
      send(0, 1'b1, 32'h0100_0030, 32'hCAFE_0000, 32'h0, 1'b0);
      send(1, 1'b1, 32'h0300_0030, 32'hCAFE_0001, 32'h0, 1'b0);
    join
    repeat (5) @(posedge clk); #1;
    chk("post_reset_first_grant", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);
    chk("post_reset_grant_count", gnt_log.size(), 2);

    chk("sb_resp_empty", exp_q.size(), 0);
    chk("sb_strobe_empty", strb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
